config_mem_stream_loader: RTL

- Avalon-MM write master sitting directly upstream of the 10000 x 32 single-port on-chip RAM (14-bit word address, 4-bit byteenable, one-cycle read latency).
- Accepts a byte stream (e.g. from the UART/JTAG receive path) and packs it little-endian into 32-bit words.
- Writes each word to consecutive RAM addresses, then reads the loaded region back and checks a 32-bit additive checksum.
- Used to preload the Nios II program/data memory without re-synthesis.

---
 rtl/config_mem_stream_loader_if.sv | 28 ++
 rtl/config_mem_stream_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/config_mem_stream_loader_if.sv
// Byte-stream input and Avalon-MM RAM port of the config memory loader.
// master = loader side, slave = stream source plus on-chip RAM.
interface config_mem_stream_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  in_data, in_valid, mem_readdata,
        output in_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        output in_data, in_valid, mem_readdata,
        input  in_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/config_mem_stream_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them to
// consecutive RAM words, then reads the region back and checks the
// additive checksum. All outputs come straight from flops.
module config_mem_stream_loader #(
    parameter int ADDR_W    = 14,
    parameter int DEPTH     = 10000,
    parameter int BASE_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         length,
    config_mem_stream_loader_if.master bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t state, next_state;

    // registered outputs and their next values
    logic              busy_d, done_d, error_d;
    logic [31:0]       checksum_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              clken_q;
    logic [3:0]        be_q;

    // internal state
    logic [23:0]       pack_q, pack_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [31:0]       vsum_q, vsum_d;
    logic              last_wr_q, last_wr_d;
    logic              rd_vld_q, rd_vld_d;

    logic [31:0]       len_end;
    logic              len_fault;
    logic [31:0]       packed_word;
    logic [ADDR_W-1:0] last_addr;

    assign len_end     = 32'(BASE_ADDR) + 32'(length);
    assign len_fault   = len_end > 32'(DEPTH);
    assign packed_word = {bus.in_data, pack_q};
    assign last_addr   = BASE + len_q - ADDR_W'(1);

    assign bus.in_ready       = in_ready_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.mem_clken      = clken_q;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (length == '0 || len_fault) ? DONE : LOAD;
            LOAD:    if (last_wr_q) next_state = VERIFY;
            VERIFY:  if (rd_vld_q && !cs_q) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // next values of outputs and datapath registers
    always_comb begin
        busy_d      = busy;
        done_d      = 1'b0;
        error_d     = error;
        checksum_d  = checksum;
        in_ready_d  = in_ready_q;
        addr_d      = addr_q;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        wdata_d     = wdata_q;
        pack_d      = pack_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        vsum_d      = vsum_q;
        last_wr_d   = 1'b0;
        // a read address presented this cycle returns data next cycle
        rd_vld_d    = (state == VERIFY) && cs_q;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    checksum_d = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    vsum_d     = '0;
                    pack_d     = '0;
                    len_d      = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else if (len_fault) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: pack_d[7:0]   = bus.in_data;
                        2'd1: pack_d[15:8]  = bus.in_data;
                        2'd2: pack_d[23:16] = bus.in_data;
                        default: begin
                            // fourth byte completes the word: issue a one-cycle write
                            wdata_d    = packed_word;
                            addr_d     = BASE + word_cnt_q;
                            cs_d       = 1'b1;
                            wr_d       = 1'b1;
                            checksum_d = checksum + packed_word;
                            word_cnt_d = word_cnt_q + ADDR_W'(1);
                            if (word_cnt_q == len_q - ADDR_W'(1)) begin
                                in_ready_d = 1'b0;
                                last_wr_d  = 1'b1;
                            end
                        end
                    endcase
                end
                // final write cycle ends: present the first readback address
                if (last_wr_q) begin
                    addr_d = BASE;
                    cs_d   = 1'b1;
                end
            end
            VERIFY: begin
                if (rd_vld_q) vsum_d = vsum_q + bus.mem_readdata;
                if (cs_q) begin
                    if (addr_q != last_addr) begin
                        cs_d   = 1'b1;
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                // last data beat: fold it in and compare
                if (rd_vld_q && !cs_q) begin
                    error_d = (vsum_q + bus.mem_readdata) != checksum;
                    done_d  = 1'b1;
                end
            end
            DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    // output and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            clken_q    <= 1'b0;
            be_q       <= 4'hF;
            pack_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            vsum_q     <= '0;
            last_wr_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            checksum   <= checksum_d;
            in_ready_q <= in_ready_d;
            addr_q     <= addr_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            clken_q    <= 1'b1;
            be_q       <= 4'hF;
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            vsum_q     <= vsum_d;
            last_wr_q  <= last_wr_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

endmodule
